// File: rtl/src_stream_ctrl.sv
// ----------------------------------------------------------------------------
// src_stream_ctrl
//
// Receive-side stream controller. Once armed by a start pulse it accepts a
// single valid/ready packet from the source stream. It writes each accepted
// beat into the local buffer at incrementing addresses. On the final beat it
// pulses recv_fin and leaves the word count on recv_cnt.
//
// If a packet is longer than the buffer depth (2**AW words), the block keeps
// accepting the remaining beats until the last one and throws them away. It
// also raises the sticky overflow flag.
//
// Parameters
//   DW  stream / buffer data width in bits
//   AW  buffer address width; buffer depth is 2**AW words
//
// Ports
//   clk        clock
//   rst        synchronous active-high reset
//   start      one-cycle arm pulse, honoured only while idle
//   mem_ready  buffer can take a write this cycle
//   src_valid  source beat valid
//   src_last   final beat of the packet, qualified by src_valid
//   src_data   source beat data
//   src_ready  beat accepted when src_valid & src_ready (combinational)
//   mem_we     registered buffer write enable
//   mem_addr   registered buffer write address
//   mem_wdata  registered buffer write data
//   recv_fin   one-cycle completion pulse, aligned with the final write
//   recv_cnt   words written for the current / last packet
//   overflow   sticky: packet was longer than the buffer
//   busy       controller is not idle
// ----------------------------------------------------------------------------
module src_stream_ctrl #(
    parameter int DW = 32,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mem_ready,
    input  logic          src_valid,
    input  logic          src_last,
    input  logic [DW-1:0] src_data,
    output logic          src_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          recv_fin,
    output logic [AW:0]   recv_cnt,
    output logic          overflow,
    output logic          busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RECV  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

    // Buffer depth expressed in the width of the word counter.
    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [1:0]    state_r;
    logic          mem_we_r;
    logic [AW-1:0] mem_addr_r;
    logic [DW-1:0] mem_wdata_r;
    logic          recv_fin_r;
    logic [AW:0]   recv_cnt_r;
    logic          overflow_r;

    logic          src_ready_s;
    logic          accept_s;
    logic [AW:0]   cnt_inc_s;

    // Ready generation. While receiving, ready follows the buffer. While
    // draining, beats are sunk unconditionally.
    always_comb begin
        src_ready_s = 1'b0;
        case (state_r)
            ST_IDLE:  src_ready_s = 1'b0;
            ST_RECV:  src_ready_s = mem_ready;
            ST_DRAIN: src_ready_s = 1'b1;
            ST_FIN:   src_ready_s = 1'b0;
            default:  src_ready_s = 1'b0;
        endcase
    end

    // Handshake qualification and the next value of the word count.
    always_comb begin
        accept_s  = src_valid & src_ready_s;
        cnt_inc_s = recv_cnt_r + {{AW{1'b0}}, 1'b1};
    end

    // Control FSM, buffer write port and status registers. The low AW bits of
    // the word count double as the write pointer. While receiving, the count
    // is always below DEPTH, so every beat accepted in that state is written.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {AW{1'b0}};
            mem_wdata_r <= {DW{1'b0}};
            recv_fin_r  <= 1'b0;
            recv_cnt_r  <= {(AW+1){1'b0}};
            overflow_r  <= 1'b0;
        end else begin
            mem_we_r   <= 1'b0;
            recv_fin_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r    <= ST_RECV;
                        recv_cnt_r <= {(AW+1){1'b0}};
                        overflow_r <= 1'b0;
                    end
                end
                ST_RECV: begin
                    if (accept_s) begin
                        mem_we_r    <= 1'b1;
                        mem_addr_r  <= recv_cnt_r[AW-1:0];
                        mem_wdata_r <= src_data;
                        recv_cnt_r  <= cnt_inc_s;
                        if (src_last) begin
                            // An exact fill that ends on the last beat is not
                            // an overflow.
                            state_r    <= ST_FIN;
                            recv_fin_r <= 1'b1;
                        end else if (cnt_inc_s == DEPTH) begin
                            state_r    <= ST_DRAIN;
                            overflow_r <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    // recv_cnt is left at DEPTH, so it saturates there.
                    if (accept_s && src_last) begin
                        state_r    <= ST_FIN;
                        recv_fin_r <= 1'b1;
                    end
                end
                ST_FIN: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign src_ready = src_ready_s;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign recv_fin  = recv_fin_r;
    assign recv_cnt  = recv_cnt_r;
    assign overflow  = overflow_r;
    assign busy      = (state_r != ST_IDLE);

endmodule
